// File: rtl/mem_arbiter_v1.sv
// Round-robin arbiter and sequencer sharing one single-ported memory unit
// between the instruction-fetch (IF) and load/store (LS) ports.
module mem_arbiter_v1 #(
    parameter int addr_width   = 10,
    parameter int data_width   = 32,
    parameter int read_latency = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [addr_width-1:0] if_addr,
    output logic                  if_ready,
    output logic                  if_rvalid,
    output logic [data_width-1:0] if_rdata,

    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [addr_width-1:0] ls_addr,
    input  logic [data_width-1:0] ls_wdata,
    output logic                  ls_ready,
    output logic                  ls_rvalid,
    output logic [data_width-1:0] ls_rdata,

    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_data_in,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    input  logic [data_width-1:0] mem_data_out,

    output logic                  busy,
    output logic                  last_grant
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       owner_ls;
    logic       lat_we;
    logic       grant_if;
    logic       grant_ls;

    // On contention the port that did not win last time is favoured.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (ls_req && (!if_req || !last_grant)) begin
            grant_ls = 1'b1;
        end else if (if_req) begin
            grant_if = 1'b1;
        end
    end

    assign if_ready = (state == IDLE) && grant_if;
    assign ls_ready = (state == IDLE) && grant_ls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            last_grant       <= 1'b1;
            owner_ls         <= 1'b0;
            lat_we           <= 1'b0;
            cnt              <= '0;
            mem_addr         <= '0;
            mem_data_in      <= '0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            if_rvalid        <= 1'b0;
            ls_rvalid        <= 1'b0;
            if_rdata         <= '0;
            ls_rdata         <= '0;
        end else begin
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            if_rvalid        <= 1'b0;
            ls_rvalid        <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_if || grant_ls) begin
                        // mem_addr/mem_data_in double as the latched request.
                        owner_ls         <= grant_ls;
                        last_grant       <= grant_ls;
                        lat_we           <= grant_ls && ls_we;
                        mem_addr         <= grant_ls ? ls_addr : if_addr;
                        if (grant_ls) begin
                            mem_data_in <= ls_wdata;
                        end
                        mem_write_enable <= grant_ls && ls_we;
                        mem_read_enable  <= !(grant_ls && ls_we);
                        busy             <= 1'b1;
                        state            <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (lat_we) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt   <= 3'(read_latency);
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (cnt == 3'd1) begin
                        if (owner_ls) begin
                            ls_rdata  <= mem_data_out;
                            ls_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_data_out;
                            if_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end

                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_v1.sv
// Bench for mem_arbiter_v1: directed sequences, an arbitration vector table and
// a randomized run against a transaction-level schedule model (L=1 and L=3 units).
module tb_mem_arbiter_v1;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int L1 = 1;
    localparam int L3 = 3;
    localparam logic [DW-1:0] NOREAD = 32'hBAD0BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req, ls_req, ls_we;
    logic [AW-1:0] if_addr, ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          if_ready, if_rvalid, ls_ready, ls_rvalid;
    logic [DW-1:0] if_rdata, ls_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in, mem_dout;
    logic          mem_we, mem_re, busy, last_grant;

    logic          q_if_req;
    logic [AW-1:0] q_if_addr;
    logic          q_if_ready, q_if_rvalid, q_ls_ready, q_ls_rvalid;
    logic [DW-1:0] q_if_rdata, q_ls_rdata;
    logic [AW-1:0] q_mem_addr;
    logic [DW-1:0] q_mem_din, q_mem_dout;
    logic          q_mem_we, q_mem_re, q_busy, q_last_grant;

    mem_arbiter_v1 #(.addr_width(AW), .data_width(DW), .read_latency(L1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_we), .mem_read_enable(mem_re),
        .mem_data_out(mem_dout), .busy(busy), .last_grant(last_grant)
    );

    mem_arbiter_v1 #(.addr_width(AW), .data_width(DW), .read_latency(L3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(q_if_req), .if_addr(q_if_addr), .if_ready(q_if_ready),
        .if_rvalid(q_if_rvalid), .if_rdata(q_if_rdata),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr('0), .ls_wdata('0),
        .ls_ready(q_ls_ready), .ls_rvalid(q_ls_rvalid), .ls_rdata(q_ls_rdata),
        .mem_addr(q_mem_addr), .mem_data_in(q_mem_din),
        .mem_write_enable(q_mem_we), .mem_read_enable(q_mem_re),
        .mem_data_out(q_mem_dout), .busy(q_busy), .last_grant(q_last_grant)
    );

    // Memory units: synchronous read, data valid L cycles after the read strobe.
    logic [DW-1:0] mem1 [1024];
    logic [DW-1:0] mem3 [1024];
    logic [DW-1:0] p1;
    logic [DW-1:0] p3 [3];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always_ff @(posedge clk) begin
        if (pre_we) begin
            mem1[pre_addr] <= pre_data;
            mem3[pre_addr] <= pre_data;
        end else begin
            if (mem_we)   mem1[mem_addr]   <= mem_data_in;
            if (q_mem_we) mem3[q_mem_addr] <= q_mem_din;
        end
        p1    <= mem_re   ? mem1[mem_addr]   : NOREAD;
        p3[0] <= q_mem_re ? mem3[q_mem_addr] : NOREAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_dout   = p1;
    assign q_mem_dout = p3[2];

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] shadow [1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    // Called at the drive point just after the accept cycle; ends at a drive point.
    task automatic wait_rv(input bit port_ls, input int maxc, output int lat,
                           output int pulses, output logic [DW-1:0] data);
        lat = -1; pulses = 0; data = '0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (port_ls ? ls_rvalid : if_rvalid) begin
                pulses++;
                if (lat < 0) begin
                    lat  = i + 1;
                    data = port_ls ? ls_rdata : if_rdata;
                end
            end
            step();
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 12) begin
            step();
            @(negedge clk);
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    typedef struct {
        bit            if_req;
        bit            ls_req;
        bit            ls_we;
        logic [DW-1:0] wdata;
        bit            exp_if_rdy;
        bit            exp_ls_rdy;
        bit            exp_last;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl [9];
        int lat, pulses, we_cnt, ng, pend_owner, cyc, idle_at, acc_cyc, rv_cyc;
        bit pend, idle, win_if, win_ls, acc_we, rv_ls, m_last;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] acc_wd, rv_data, got;

        tbl[0] = '{1, 1, 0, 32'h0, 1, 0, 0};
        tbl[1] = '{1, 1, 0, 32'h0, 0, 1, 1};
        tbl[2] = '{0, 0, 0, 32'h0, 0, 0, 1};
        tbl[3] = '{0, 1, 1, 32'hA5A5_0001, 0, 1, 1};
        tbl[4] = '{1, 0, 0, 32'h0, 1, 0, 0};
        tbl[5] = '{0, 1, 0, 32'h0, 0, 1, 1};
        tbl[6] = '{1, 1, 1, 32'hA5A5_0002, 1, 0, 0};
        tbl[7] = '{1, 0, 0, 32'h0, 1, 0, 0};
        tbl[8] = '{1, 1, 1, 32'hA5A5_0003, 0, 1, 1};

        rst = 1'b1; if_req = 0; ls_req = 0; ls_we = 0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        q_if_req = 0; q_if_addr = '0;
        pre_we = 0; pre_addr = '0; pre_data = '0;

        // ---- reset values ----
        repeat (2) @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_data_in, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_ls_rvalid", ls_rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last_grant", last_grant, 1);
        step();
        rst = 1'b0;
        preload(10'h004, 32'hDEADBEEF);
        for (int i = 0; i < 16; i++) begin
            shadow[10'h100 + i] = $urandom;
            preload(10'(10'h100 + i), shadow[10'h100 + i]);
        end

        // ---- IF read of 0x004 ----
        if_req = 1; if_addr = 10'h004;
        @(negedge clk);
        chk("ifrd_if_ready_c0", if_ready, 1);
        chk("ifrd_ls_ready_c0", ls_ready, 0);
        step(); if_req = 0; if_addr = 10'h3FF;
        @(negedge clk);
        chk("ifrd_re_c1", mem_re, 1);
        chk("ifrd_we_c1", mem_we, 0);
        chk("ifrd_addr_c1", mem_addr, 10'h004);
        step(); @(negedge clk);
        chk("ifrd_rvalid_c2", if_rvalid, 0);
        chk("ifrd_re_c2", mem_re, 0);
        step(); @(negedge clk);
        chk("ifrd_rvalid_c3", if_rvalid, 1);
        chk("ifrd_rdata_c3", if_rdata, 32'hDEADBEEF);
        chk("ifrd_ls_rvalid_c3", ls_rvalid, 0);
        step(); @(negedge clk);
        chk("ifrd_rvalid_c4", if_rvalid, 0);
        chk("ifrd_busy_c4", busy, 0);
        step();

        // ---- LS write with input changes during ACCESS, then read-back ----
        ls_req = 1; ls_we = 1; ls_addr = 10'h010; ls_wdata = 32'h12345678;
        @(negedge clk);
        chk("lswr_ls_ready", ls_ready, 1);
        step();
        ls_req = 0; ls_addr = 10'h2AA; ls_wdata = 32'hFFFF0000;
        we_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                chk("lswr_din", mem_data_in, 32'h12345678);
            end
            chk("lswr_addr_held", mem_addr, 10'h010);
            step();
        end
        chk("lswr_we_cycles", we_cnt, 1);
        ls_req = 1; ls_we = 0; ls_addr = 10'h010;
        @(negedge clk);
        chk("lsrd_ls_ready", ls_ready, 1);
        step(); ls_req = 0;
        wait_rv(1'b1, 6, lat, pulses, got);
        chk("lsrd_latency", lat, 3);
        chk("lsrd_pulses", pulses, 1);
        chk("lsrd_data", got, 32'h12345678);

        // ---- arbitration vector table ----
        for (int r = 0; r < 9; r++) begin
            if_req = tbl[r].if_req; ls_req = tbl[r].ls_req; ls_we = tbl[r].ls_we;
            if_addr = 10'h020; ls_addr = 10'h030; ls_wdata = tbl[r].wdata;
            @(negedge clk);
            chk($sformatf("tbl%0d_if_ready", r), if_ready, tbl[r].exp_if_rdy);
            chk($sformatf("tbl%0d_ls_ready", r), ls_ready, tbl[r].exp_ls_rdy);
            step();
            if_req = 0; ls_req = 0;
            wait_idle($sformatf("tbl%0d_idle", r));
            chk($sformatf("tbl%0d_last_grant", r), last_grant, tbl[r].exp_last);
            step();
        end

        // ---- contention from reset ----
        if_req = 1; ls_req = 1; ls_we = 0; if_addr = 10'h004; ls_addr = 10'h010;
        rst = 1;
        @(negedge clk);
        step(); rst = 0;
        ng = 0; pend = 0; pend_owner = 0;
        for (int i = 0; i < 40 && !(ng >= 4 && !pend); i++) begin
            @(negedge clk);
            chk("cont_exclusive", if_ready & ls_ready, 0);
            if (pend) begin
                chk($sformatf("cont_last_grant%0d", ng - 1), last_grant, pend_owner);
                pend = 0;
            end
            if (if_ready || ls_ready) begin
                if (ng < 4) chk($sformatf("cont_grant%0d", ng), ls_ready, ng % 2);
                ng++;
                pend = 1;
                pend_owner = ls_ready ? 1 : 0;
            end
            step();
        end
        chk("cont_grant_count", (ng >= 4) ? 1 : 0, 1);
        if_req = 0; ls_req = 0;
        wait_idle("cont_idle");
        step();

        // ---- reset during WAIT of an LS read ----
        ls_req = 1; ls_we = 0; ls_addr = 10'h004;
        @(negedge clk);
        chk("rstw_ls_ready", ls_ready, 1);
        step(); ls_req = 0;
        step();
        rst = 1;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_ls_rvalid", ls_rvalid, 0);
        chk("rstw_mem_re", mem_re, 0);
        chk("rstw_mem_addr", mem_addr, 0);
        chk("rstw_ls_rdata", ls_rdata, 0);
        chk("rstw_if_rdata", if_rdata, 0);
        chk("rstw_last_grant", last_grant, 1);
        @(negedge clk);
        step(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstw_no_rvalid", ls_rvalid, 0);
            step();
        end
        ls_req = 1; ls_addr = 10'h004;
        @(negedge clk);
        chk("rstw_reaccept", ls_ready, 1);
        step(); ls_req = 0;
        wait_rv(1'b1, 6, lat, pulses, got);
        chk("rstw_rd_latency", lat, 3);
        chk("rstw_rd_data", got, 32'hDEADBEEF);

        // ---- read latency 3 ----
        q_if_req = 1; q_if_addr = 10'h004;
        @(negedge clk);
        chk("l3_if_ready", q_if_ready, 1);
        step(); q_if_req = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("l3_busy_c%0d", c), q_busy, (c <= 5) ? 1 : 0);
            chk($sformatf("l3_rvalid_c%0d", c), q_if_rvalid, (c == 5) ? 1 : 0);
            chk($sformatf("l3_ls_rvalid_c%0d", c), q_ls_rvalid, 0);
            if (c == 5) chk("l3_rdata", q_if_rdata, 32'hDEADBEEF);
            step();
        end

        // ---- randomized traffic against a transaction schedule model ----
        rst = 1;
        @(negedge clk);
        step(); rst = 0;
        cyc = 0; idle_at = 0; acc_cyc = -1; rv_cyc = -1;
        acc_we = 0; rv_ls = 0; m_last = 1; m_addr = '0; acc_wd = '0; rv_data = '0;
        for (int n = 0; n < 600; n++) begin
            if_req   = ($urandom_range(0, 2) != 0);
            ls_req   = ($urandom_range(0, 2) != 0);
            ls_we    = ($urandom_range(0, 1) != 0);
            if_addr  = 10'h100 + 10'($urandom_range(0, 15));
            ls_addr  = 10'h100 + 10'($urandom_range(0, 15));
            ls_wdata = $urandom;
            @(negedge clk);
            idle   = (cyc >= idle_at);
            win_if = idle && if_req && (!ls_req || m_last);
            win_ls = idle && ls_req && !win_if;
            chk("rnd_if_ready", if_ready, win_if);
            chk("rnd_ls_ready", ls_ready, win_ls);
            chk("rnd_busy", busy, !idle);
            chk("rnd_last_grant", last_grant, m_last);
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_we", mem_we, (cyc == acc_cyc) && acc_we);
            chk("rnd_mem_re", mem_re, (cyc == acc_cyc) && !acc_we);
            if (cyc == acc_cyc && acc_we) chk("rnd_mem_din", mem_data_in, acc_wd);
            chk("rnd_if_rvalid", if_rvalid, (cyc == rv_cyc) && !rv_ls);
            chk("rnd_ls_rvalid", ls_rvalid, (cyc == rv_cyc) && rv_ls);
            if (cyc == rv_cyc) chk("rnd_rdata", rv_ls ? ls_rdata : if_rdata, rv_data);
            if (win_if || win_ls) begin
                m_last  = win_ls;
                m_addr  = win_ls ? ls_addr : if_addr;
                acc_cyc = cyc + 1;
                acc_we  = win_ls && ls_we;
                if (acc_we) begin
                    acc_wd         = ls_wdata;
                    shadow[m_addr] = ls_wdata;
                    idle_at        = cyc + 2;
                end else begin
                    rv_cyc  = cyc + L1 + 2;
                    rv_ls   = win_ls;
                    rv_data = shadow[m_addr];
                    idle_at = cyc + L1 + 3;
                end
            end
            cyc++;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
